// File: rtl/det_ack_ctrl.sv
// Acknowledge controller for the serial pattern detector: counts each detection,
// holds for a programmable time, pulses en to release the detector, then re-arms.
module det_ack_ctrl #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CW          = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          w,
  input  logic          clr,
  output logic          en,
  output logic          hit,
  output logic [CW-1:0] count,
  output logic          ovf,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HOLD = 2'b01,
    ACK  = 2'b10,
    WAIT = 2'b11
  } state_e;

  // Loaded with HOLD_CYCLES so that ACK is entered HOLD_CYCLES+1 edges after w is sampled.
  localparam logic [7:0]    HOLD_LOAD = 8'(HOLD_CYCLES);
  localparam logic [CW-1:0] COUNT_MAX = '1;
  localparam logic [CW-1:0] COUNT_ONE = CW'(1);

  state_e        state_q, state_d;
  logic [7:0]    timer_q, timer_d;
  logic          hit_q, hit_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          accept;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (w) begin
          state_d = HOLD;
          timer_d = HOLD_LOAD;
          accept  = 1'b1;
        end
      end
      HOLD: begin
        if (timer_q == 8'd0) state_d = ACK;
        else                 timer_d = timer_q - 8'd1;
      end
      ACK:  state_d = WAIT;
      WAIT: if (!w) state_d = IDLE;
      default: begin
        state_d = IDLE;
        timer_d = 8'd0;
      end
    endcase
  end

  // clr wins over a same-edge detection; hit still reports the event.
  always_comb begin
    hit_d   = accept;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (accept) begin
      if (count_q != COUNT_MAX) count_d = count_q + COUNT_ONE;
      else                      ovf_d   = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= 8'd0;
      hit_q   <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      hit_q   <= hit_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign en    = (state_q == ACK);
  assign busy  = (state_q != IDLE);
  assign hit   = hit_q;
  assign count = count_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_det_ack_ctrl.sv
// Directed bench for det_ack_ctrl: a CW=8/HOLD=4 instance plus a CW=3/HOLD=1 instance for saturation.
module tb_det_ack_ctrl;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       w_drv, clr;
  logic       en, hit, ovf, busy;
  logic [7:0] count;

  logic       w3, clr3;
  logic       en3, hit3, ovf3, busy3;
  logic [2:0] count3;

  logic       loop_mode, j, det_w, w_in;
  int         det_run;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  assign w_in = loop_mode ? det_w : w_drv;

  det_ack_ctrl #(.HOLD_CYCLES(H), .CW(8)) dut (
    .clk(clk), .rst(rst), .w(w_in), .clr(clr),
    .en(en), .hit(hit), .count(count), .ovf(ovf), .busy(busy)
  );

  det_ack_ctrl #(.HOLD_CYCLES(1), .CW(3)) dut3 (
    .clk(clk), .rst(rst), .w(w3), .clr(clr3),
    .en(en3), .hit(hit3), .count(count3), .ovf(ovf3), .busy(busy3)
  );

  // Behavioural detector: w rises after five consecutive 1s on j, released by en.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      det_w   <= 1'b0;
      det_run <= 0;
    end else if (en) begin
      det_w   <= 1'b0;
      det_run <= 0;
    end else if (!det_w) begin
      if (j) begin
        det_run <= det_run + 1;
        if (det_run == 4) det_w <= 1'b1;
      end else begin
        det_run <= 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; w_drv = 1'b1; clr = 1'b0; w3 = 1'b0; clr3 = 1'b0;
    loop_mode = 1'b0; j = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      if ({en, hit, count, ovf, busy} !== 12'd0)
        $display("FAIL reset_outputs: got en=%b hit=%b count=%0d ovf=%b busy=%b exp all 0", en, hit, count, ovf, busy);
      else pass_cnt++;
      total_cnt++;
    end
    rst = 1'b0;
    step();
    if (hit !== 1'b1) $display("FAIL reset_first_hit: got %b exp 1", hit); else pass_cnt++;
    total_cnt++;
    if (count !== 8'd1) $display("FAIL reset_first_count: got %0d exp 1", count); else pass_cnt++;
    total_cnt++;
    w_drv = 1'b0;
    repeat (H + 4) step();
  endtask

  task automatic test_latency();
    int early;
    early = 0;
    w_drv = 1'b1;
    step();
    if ({hit, en, busy} !== 3'b101) $display("FAIL lat_accept: got hit/en/busy=%b exp 101", {hit, en, busy}); else pass_cnt++;
    total_cnt++;
    if (count !== 8'd2) $display("FAIL lat_count: got %0d exp 2", count); else pass_cnt++;
    total_cnt++;
    for (int k = 1; k <= H; k++) begin
      step();
      if (en || hit) early++;
    end
    if (early !== 0) $display("FAIL lat_early_pulse: got %0d exp 0", early); else pass_cnt++;
    total_cnt++;
    step();
    if ({en, hit} !== 2'b10) $display("FAIL lat_en: got en/hit=%b exp 10", {en, hit}); else pass_cnt++;
    total_cnt++;
    w_drv = 1'b0;
    step();
    if ({en, busy} !== 2'b01) $display("FAIL lat_wait: got en/busy=%b exp 01", {en, busy}); else pass_cnt++;
    total_cnt++;
    step();
    if (busy !== 1'b0) $display("FAIL lat_rearm: got busy=%b exp 0", busy); else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_stuck_w();
    int hits, ens;
    hits = 0; ens = 0;
    w_drv = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (hit) hits++;
      if (en) ens++;
    end
    if (hits !== 1) $display("FAIL stuck_hits: got %0d exp 1", hits); else pass_cnt++;
    total_cnt++;
    if (ens !== 1) $display("FAIL stuck_en: got %0d exp 1", ens); else pass_cnt++;
    total_cnt++;
    if (count !== 8'd3) $display("FAIL stuck_count: got %0d exp 3", count); else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL stuck_busy: got %b exp 1", busy); else pass_cnt++;
    total_cnt++;
    w_drv = 1'b0;
    step(); step();
    if (busy !== 1'b0) $display("FAIL stuck_release: got busy=%b exp 0", busy); else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_saturation();
    for (int n = 1; n <= 9; n++) begin
      w3 = 1'b1;
      step();
      w3 = 1'b0;
      repeat (4) step();
      if (n == 7) begin
        if ({count3, ovf3} !== {3'd7, 1'b0}) $display("FAIL sat_7: got count=%0d ovf=%b exp 7/0", count3, ovf3); else pass_cnt++;
        total_cnt++;
      end
      if (n == 8) begin
        if ({count3, ovf3} !== {3'd7, 1'b1}) $display("FAIL sat_8: got count=%0d ovf=%b exp 7/1", count3, ovf3); else pass_cnt++;
        total_cnt++;
      end
      if (n == 9) begin
        if ({count3, ovf3, busy3} !== {3'd7, 1'b1, 1'b0}) $display("FAIL sat_9: got count=%0d ovf=%b busy=%b exp 7/1/0", count3, ovf3, busy3); else pass_cnt++;
        total_cnt++;
      end
    end
    clr3 = 1'b1;
    step();
    clr3 = 1'b0;
    if ({count3, ovf3} !== 4'd0) $display("FAIL sat_clr: got count=%0d ovf=%b exp 0/0", count3, ovf3); else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_clr_collision();
    int early;
    early = 0;
    w_drv = 1'b1; clr = 1'b1;
    step();
    clr = 1'b0; w_drv = 1'b0;
    if ({hit, count, ovf} !== {1'b1, 8'd0, 1'b0}) $display("FAIL clr_coll: got hit=%b count=%0d ovf=%b exp 1/0/0", hit, count, ovf); else pass_cnt++;
    total_cnt++;
    for (int k = 1; k <= H; k++) begin
      step();
      if (en) early++;
    end
    if (early !== 0) $display("FAIL clr_coll_early_en: got %0d exp 0", early); else pass_cnt++;
    total_cnt++;
    step();
    if (en !== 1'b1) $display("FAIL clr_coll_en: got %b exp 1", en); else pass_cnt++;
    total_cnt++;
    step(); step();
    if ({busy, count} !== {1'b0, 8'd0}) $display("FAIL clr_coll_end: got busy=%b count=%0d exp 0/0", busy, count); else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_reset_mid_hold();
    int ens;
    ens = 0;
    w_drv = 1'b1;
    step();
    w_drv = 1'b0;
    step();
    rst = 1'b1;
    #1;
    if ({busy, en} !== 2'b00) $display("FAIL rst_hold_async: got busy/en=%b exp 00", {busy, en}); else pass_cnt++;
    total_cnt++;
    for (int i = 0; i < 6; i++) begin
      step();
      if (en) ens++;
    end
    if (ens !== 0) $display("FAIL rst_hold_no_en: got %0d exp 0", ens); else pass_cnt++;
    total_cnt++;
    rst = 1'b0;
    w_drv = 1'b1;
    step();
    w_drv = 1'b0;
    if ({hit, count} !== {1'b1, 8'd1}) $display("FAIL rst_hold_rehit: got hit=%b count=%0d exp 1/1", hit, count); else pass_cnt++;
    total_cnt++;
    for (int i = 0; i < H + 3; i++) begin
      step();
      if (en) ens++;
    end
    if ({ens == 1, busy} !== 2'b10) $display("FAIL rst_hold_recover: got en_pulses=%0d busy=%b exp 1/0", ens, busy); else pass_cnt++;
    total_cnt++;
  endtask

  task automatic test_closed_loop();
    logic seq [7];
    int k_hit, k_en, k_wlow, ens;
    seq = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    k_hit = -1; k_en = -1; k_wlow = -1; ens = 0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    loop_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      j = (i < 7) ? seq[i] : 1'b0;
      step();
      if (hit && k_hit < 0) k_hit = i;
      if (en) begin
        ens++;
        if (k_en < 0) k_en = i;
      end
      if (k_en >= 0 && !det_w && k_wlow < 0) k_wlow = i;
    end
    loop_mode = 1'b0;
    if (k_hit < 0 || k_en < 0) begin
      $display("FAIL loop_timeout: got hit_at=%0d en_at=%0d exp both seen", k_hit, k_en);
    end else begin
      if (k_en - k_hit !== H + 1) $display("FAIL loop_latency: got %0d exp %0d", k_en - k_hit, H + 1); else pass_cnt++;
      total_cnt++;
      if (k_wlow - k_en !== 1) $display("FAIL loop_w_drop: got %0d exp 1", k_wlow - k_en); else pass_cnt++;
    end
    total_cnt++;
    if ({ens == 1, count, busy} !== {1'b1, 8'd1, 1'b0}) $display("FAIL loop_end: got en_pulses=%0d count=%0d busy=%b exp 1/1/0", ens, count, busy); else pass_cnt++;
    total_cnt++;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stuck_w();
    test_saturation();
    test_clr_collision();
    test_reset_mid_hold();
    test_closed_loop();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
